// File: rtl/cache_pkg.sv
// Shared definitions for the cache fill controller.
// Holds the FSM state encoding, default geometry and a helper that sizes the
// FILL_WAIT timeout counter.
package cache_pkg;

    localparam int DEF_ADDR_WIDTH   = 8;
    localparam int DEF_LINE_WIDTH   = 32;
    localparam int DEF_FILL_TIMEOUT = 8;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        LOOKUP    = 4'd1,
        CHECK     = 4'd2,
        MEM_REQ   = 4'd3,
        MEM_WAIT  = 4'd4,
        WR_MEM    = 4'd5,
        FILL      = 4'd6,
        FILL_WAIT = 4'd7,
        RESP      = 4'd8
    } state_e;

    // Counter must be able to hold the value FILL_TIMEOUT itself.
    function automatic int tmo_cnt_width(input int timeout);
        if (timeout < 1) begin
            return 1;
        end else begin
            return $clog2(timeout + 1);
        end
    endfunction

endpackage

// File: rtl/cache_fill_ctrl.sv
// Miss-handling / fill controller in front of a two-entry line cache.
// Accepts one requester transaction at a time, probes the cache on reads,
// fetches missing lines from backing memory and installs them, and handles
// writes as write-through (memory first, then cache update/allocate).
//
// Ports:
//   clock, reset             : single clock, synchronous active-high reset
//   req_*                    : requester command (valid/ready handshake)
//   resp_*                   : response with read data, first-probe hit, timeout error
//   cache_read/write/addr/wdata, cache_hit/rdata : cache interface (cache outputs registered)
//   mem_req_*, mem_resp_*    : backing memory command and read-data return
module cache_fill_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int LINE_WIDTH   = DEF_LINE_WIDTH,
    parameter int FILL_TIMEOUT = DEF_FILL_TIMEOUT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LINE_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [LINE_WIDTH-1:0] resp_rdata,
    output logic                  resp_hit,
    output logic                  resp_error,
    output logic                  cache_read,
    output logic                  cache_write,
    output logic [ADDR_WIDTH-1:0] cache_addr,
    output logic [LINE_WIDTH-1:0] cache_wdata,
    input  logic                  cache_hit,
    input  logic [LINE_WIDTH-1:0] cache_rdata,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_write,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [LINE_WIDTH-1:0] mem_req_wdata,
    input  logic                  mem_resp_valid,
    input  logic [LINE_WIDTH-1:0] mem_resp_rdata
);

    localparam int            CW       = tmo_cnt_width(FILL_TIMEOUT);
    localparam logic [CW-1:0] TMO_LAST = CW'(FILL_TIMEOUT - 1);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [LINE_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    write_q, write_d;
    logic [LINE_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    hit_q, hit_d;
    logic                    error_q, error_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    idle_ready_s;

    // Next-state, datapath updates and state-decoded strobes.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        write_d       = write_q;
        rdata_d       = rdata_q;
        hit_d         = hit_q;
        error_d       = error_q;
        cnt_d         = cnt_q;
        idle_ready_s  = 1'b0;
        cache_read    = 1'b0;
        cache_write   = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_write = 1'b0;
        case (state_q)
            IDLE: begin
                idle_ready_s = 1'b1;
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    write_d = req_write;
                    rdata_d = '0;
                    hit_d   = 1'b0;
                    error_d = 1'b0;
                    state_d = req_write ? WR_MEM : LOOKUP;
                end else begin
                    state_d = IDLE;
                end
            end
            LOOKUP: begin
                cache_read = 1'b1;
                state_d    = CHECK;
            end
            CHECK: begin
                // Cache registered hit/data on the LOOKUP edge.
                if (cache_hit) begin
                    rdata_d = cache_rdata;
                    hit_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    hit_d   = 1'b0;
                    state_d = MEM_REQ;
                end
            end
            MEM_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_d = MEM_WAIT;
                end else begin
                    state_d = MEM_REQ;
                end
            end
            MEM_WAIT: begin
                // Fetched line becomes both the fill data and the response data.
                if (mem_resp_valid) begin
                    wdata_d = mem_resp_rdata;
                    rdata_d = mem_resp_rdata;
                    state_d = FILL;
                end else begin
                    state_d = MEM_WAIT;
                end
            end
            WR_MEM: begin
                mem_req_valid = 1'b1;
                mem_req_write = 1'b1;
                rdata_d       = '0;
                if (mem_req_ready) begin
                    state_d = FILL;
                end else begin
                    state_d = WR_MEM;
                end
            end
            FILL: begin
                cache_write = 1'b1;
                cnt_d       = '0;
                state_d     = FILL_WAIT;
            end
            FILL_WAIT: begin
                // Write held so the cache can install; hit confirms the line is resident.
                cache_write = 1'b1;
                cnt_d       = cnt_q + CW'(1);
                if (write_q && (cnt_q == '0)) begin
                    // First wait cycle reflects the FILL-edge probe: was the line already there.
                    hit_d = cache_hit;
                end else begin
                    hit_d = hit_q;
                end
                if (cache_hit) begin
                    state_d = RESP;
                end else if (cnt_q == TMO_LAST) begin
                    error_d = 1'b1;
                    state_d = RESP;
                end else begin
                    state_d = FILL_WAIT;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    error_d = 1'b0;
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            rdata_q <= '0;
            hit_q   <= 1'b0;
            error_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            rdata_q <= rdata_d;
            hit_q   <= hit_d;
            error_q <= error_d;
            cnt_q   <= cnt_d;
        end
    end

    assign req_ready     = idle_ready_s & ~reset;
    assign resp_valid    = (state_q == RESP);
    assign resp_rdata    = rdata_q;
    assign resp_hit      = hit_q;
    assign resp_error    = error_q;
    assign cache_addr    = addr_q;
    assign cache_wdata   = wdata_q;
    assign mem_req_addr  = addr_q;
    assign mem_req_wdata = wdata_q;

endmodule
